iter_div: RTL
=============

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are 2..64.
REQ-002 SHALL size its iteration counter as cf_math_pkg::idx_width(WIDTH+1) bits; this is a derived localparam, not overridable.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  cancels any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a request.
REQ-008 SHALL have port dividend  input  WIDTH  numerator.
REQ-009 SHALL have port divisor  input  WIDTH  denominator.
REQ-010 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 SHALL have port round_up  input  1  ceiling quotient; honoured only when is_signed=0.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port quotient  output  WIDTH  result quotient.
REQ-015 SHALL have port remainder  output  WIDTH  result remainder.
REQ-016 SHALL have port div_by_zero  output  1  divisor was zero; valid with out_valid.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE with flush=0; a request is accepted on in_valid&&in_ready, and operands, is_signed and round_up are registered on that edge.
REQ-019 SHALL perform radix-2 restoring division on operand magnitudes in CALC, exactly one quotient bit per cycle, for WIDTH cycles.
REQ-020 SHALL, in FIX, apply sign correction: quotient negated when operand signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-021 SHALL, in FIX with round_up=1 and unsigned mode, increment the quotient when the remainder is nonzero; remainder = dividend - quotient*divisor mod 2^WIDTH.
REQ-022 SHALL, on divisor==0, return quotient all-ones, remainder=dividend and div_by_zero=1 in either mode.
REQ-023 SHALL, for signed most-negative / -1, return quotient = most-negative and remainder = 0, with no flag.
REQ-024 SHALL assert out_valid in DONE; the first out_valid cycle is WIDTH+2 cycles after the accept edge.
REQ-025 SHALL hold quotient, remainder and div_by_zero stable while out_valid=1 and out_ready=0.
REQ-026 SHALL move DONE->IDLE on out_valid&&out_ready; no new accept in that same cycle.
REQ-027 SHALL, on flush=1, enter IDLE on the next edge from any state, discard the operation, and drop out_valid; flush outranks a simultaneous in_valid or out_ready.
REQ-028 SHALL drive quotient, remainder and div_by_zero to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, on rst=1, enter IDLE; clear the counter and all datapath registers; drive out_valid=0, quotient=0, remainder=0 and div_by_zero=0; drive in_ready=1 from the first cycle after rst deasserts.
REQ-030 SHALL let rst outrank flush and all handshakes; rst mid-CALC abandons the operation and produces no out_valid.

Configuration
REQ-031 SHALL gate an early-exit path with macro ITER_DIV_EARLY_EXIT_EN.
REQ-032 SHALL, when ITER_DIV_EARLY_EXIT_EN is defined and at accept divisor==0 or |dividend| < |divisor|, skip CALC (IDLE->FIX), making out_valid first high 2 cycles after accept; results are identical to the full path.
REQ-033 SHALL, when ITER_DIV_EARLY_EXIT_EN is undefined, always traverse CALC with fixed latency WIDTH+2.

Verification (WIDTH=32)
REQ-034 SHALL cover: unsigned 100/7 -> quotient 14, remainder 2, out_valid exactly 34 cycles after accept.
REQ-035 SHALL cover: unsigned round_up 100/7 -> quotient 15, remainder 0xFFFFFFFB; signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-036 SHALL cover: 5/0 both modes -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-037 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: flush at CALC cycle 5, with in_valid also high -> in_ready=1 next cycle, no out_valid, next 9/3 request gives 3/0; rst at CALC cycle 10 -> all outputs 0.
REQ-039 SHALL cover: 3/10 -> quotient 0, remainder 3, out_valid 2 cycles after accept with ITER_DIV_EARLY_EXIT_EN and 34 cycles after without.

Source files
------------

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider: signed/unsigned, optional ceiling quotient.
// Build option ITER_DIV_EARLY_EXIT_EN skips iteration for zero divisor or |dividend| < |divisor|.
package cf_math_pkg;
    function automatic int idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 1;
    endfunction
endpackage

// state | meaning
// IDLE  | waiting for a request; in_ready high unless flushing
// CALC  | one restoring-division step per cycle on operand magnitudes
// FIX   | two cycles: sign / ceiling / divide-by-zero correction, then result load
// DONE  | result presented until out_ready
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             round_up,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cf_math_pkg::idx_width(WIDTH + 1);
    localparam logic [CW-1:0] CNT_CALC = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             rnd_q;
    logic             dvz_q;
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg_in;
    logic             dvs_neg_in;
    logic [WIDTH-1:0] dvd_abs_in;
    logic [WIDTH-1:0] dvs_abs_in;
    logic             early;
    logic [WIDTH:0]   trial_base;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_ok;

    always_comb begin
        dvd_neg_in = is_signed & dividend[WIDTH-1];
        dvs_neg_in = is_signed & divisor[WIDTH-1];
        dvd_abs_in = dvd_neg_in ? -dividend : dividend;
        dvs_abs_in = dvs_neg_in ? -divisor : divisor;
`ifdef ITER_DIV_EARLY_EXIT_EN
        early      = (divisor == '0) || (dvd_abs_in < dvs_abs_in);
`else
        early      = 1'b0;
`endif
        // When the trial succeeds the true difference is below the divisor, so WIDTH bits suffice.
        trial_base = {rem, quo[WIDTH-1]};
        trial_ok   = trial_base >= {1'b0, dvs_mag};
        trial_diff = trial_base[WIDTH-1:0] - dvs_mag;
    end

    assign in_ready = (state == S_IDLE) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            rnd_q       <= 1'b0;
            dvz_q       <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_raw <= dividend;
                        dvs_mag <= dvs_abs_in;
                        rnd_q   <= round_up & ~is_signed;
                        dvz_q   <= (divisor == '0);
                        q_neg   <= dvd_neg_in ^ dvs_neg_in;
                        r_neg   <= dvd_neg_in;
                        if (early) begin
                            quo   <= '0;
                            rem   <= dvd_abs_in;
                            cnt   <= CW'(1);
                            state <= S_FIX;
                        end else begin
                            quo   <= dvd_abs_in;
                            rem   <= '0;
                            cnt   <= CNT_CALC;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    rem <= trial_ok ? trial_diff : trial_base[WIDTH-1:0];
                    if (cnt == '0) begin
                        cnt   <= CW'(1);
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (dvz_q) begin
                            quo <= '1;
                            rem <= dvd_raw;
                        end else if (rnd_q && (rem != '0)) begin
                            // Ceiling: one more divisor than fits, so remainder goes negative mod 2^WIDTH.
                            quo <= quo + WIDTH'(1);
                            rem <= rem - dvs_mag;
                        end else begin
                            quo <= q_neg ? -quo : quo;
                            rem <= r_neg ? -rem : rem;
                        end
                    end else begin
                        out_valid   <= 1'b1;
                        quotient    <= quo;
                        remainder   <= rem;
                        div_by_zero <= dvz_q;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
